// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM encoding and
// sizing of the per-grant burst counter.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // Wide enough to hold MAX_BURST itself.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester pick: the first set request bit strictly above
// last_idx, wrapping past NUM_REQ-1 back to bit 0.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic [NUM_REQ-1:0]         pick_oh,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   upper_mask;
  logic [2*NUM_REQ-1:0] dbl_req;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_mask[i] = (i > int'(last_idx));
    end
  end

  // Low half holds only the bits above last_idx, high half the full vector,
  // so the lowest set bit of the pair is the wrap-around round-robin winner.
  assign dbl_req = {req, req & upper_mask};
  assign any_req = |req;

  always_comb begin
    // NOTE: default first so every path assigns pick_idx and no latch is inferred.
    pick_idx = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (dbl_req[i]) pick_idx = IDX_W'(i % NUM_REQ);
    end
  end

  assign pick_oh = any_req ? (NUM_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers: round-robin grant,
// burst lock of up to MAX_BURST words, back-pressure from fifo_full.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = burst_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX_RST = IDX_W'(NUM_REQ - 1);

  logic             state;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] burst_cnt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               owner_valid;
  logic               xfer;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req      (req_valid),
    .last_idx (last_idx),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  // last_idx only moves at grant time, so during a burst it names the owner.
  assign busy        = (state == ST_BURST);
  assign owner_valid = |(req_valid & grant);
  assign xfer        = busy & owner_valid & ~fifo_full & ~rst;
  assign fifo_w_en   = xfer;
  assign req_ready   = (busy && !fifo_full && !rst) ? grant : '0;
  assign fifo_wdata  = req_data[int'(last_idx)*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      burst_cnt <= '0;
      last_idx  <= LAST_IDX_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant     <= pick_oh;
            last_idx  <= pick_idx;
            burst_cnt <= '0;
            state     <= ST_BURST;
          end
        end
        default: begin
          if (!owner_valid) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (xfer) begin
            if (burst_cnt == LAST_BEAT) begin
              state <= ST_IDLE;
              grant <= '0;
            end
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
          // A full FIFO with a valid owner stalls here with burst_cnt held.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_wdata;
  logic [N-1:0]    grant;
  logic            busy;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_w_en  (fifo_w_en),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when idle), words moved this grant,
  // and the last granted index.
  int            m_owner = -1;
  int            m_cnt   = 0;
  int            m_last  = N - 1;
  logic [DW-1:0] dat [N];
  bit            rand_data = 1'b0;

  logic          s_wen, s_busy;
  logic [N-1:0]  s_grant, s_ready;
  logic [DW-1:0] s_wdata;

  function automatic int rr_next(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check outputs at negedge, advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic full, input logic r);
    logic [N-1:0] exp_grant, exp_ready;
    logic         exp_wen;
    int           owner_at, nxt;
    req_valid = v;
    fifo_full = full;
    rst       = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
    @(negedge clk);
    s_wen = fifo_w_en; s_busy = busy; s_grant = grant;
    s_ready = req_ready; s_wdata = fifo_wdata;

    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    exp_wen   = (m_owner >= 0) && v[m_owner] && !full && !r;
    exp_ready = (m_owner >= 0 && !full && !r) ? exp_grant : '0;
    check("grant", s_grant, exp_grant);
    check("busy", s_busy, m_owner >= 0);
    check("req_ready", s_ready, exp_ready);
    check("fifo_w_en", s_wen, exp_wen);
    if (exp_wen) check("fifo_wdata", s_wdata, dat[m_owner]);

    owner_at = m_owner;
    if (r) begin
      m_owner = -1; m_cnt = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      nxt = rr_next(v, m_last);
      if (nxt >= 0) begin m_owner = nxt; m_last = nxt; m_cnt = 0; end
    end else if (!v[m_owner]) begin
      m_owner = -1;
    end else if (exp_wen) begin
      m_cnt++;
      if (m_cnt == MB) m_owner = -1;
    end

    @(posedge clk); #1;
    if (exp_wen) dat[owner_at] = rand_data ? DW'($urandom) : dat[owner_at] + 8'd1;
  endtask

  task automatic do_reset();
    cycle('0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [6:0] t1_wen;
    logic [8:0] t3_wen;
    int nw;
    t1_wen = 7'b1011110;
    t3_wen = 9'b011000110;
    for (int i = 0; i < N; i++) dat[i] = DW'(8'h40 + 8'h10 * i);
    req_valid = '0; fifo_full = 1'b0; rst = 1'b1; req_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state (model expects idle outputs and gated ready/w_en).
    do_reset();
    check("rst_busy", s_busy, 1'b0);

    // 1: single requester, bursts of four with one bubble.
    dat[0] = 8'h10; nw = 0;
    for (int c = 0; c < 7; c++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      check("t1_wen", s_wen, t1_wen[c]);
      if (s_wen) begin
        check("t1_data", s_wdata, 8'h10 + nw);
        nw++;
      end
      if (c == 1) check("t1_grant", s_grant, 4'b0001);
    end

    // 2: all requesters valid, grant order 0,1,2,3,0 with idle gaps.
    do_reset();
    for (int c = 0; c < 21; c++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      check("t2_grant", s_grant, (c % 5 == 0) ? 4'b0000 : (4'b0001 << ((c / 5) % 4)));
      check("t2_wen", s_wen, c % 5 != 0);
    end

    // 3: requester 2 stalled by a full FIFO after its second word.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cycle(4'b0100, (c >= 3 && c <= 5), 1'b0);
      check("t3_wen", s_wen, t3_wen[c]);
      if (c >= 3 && c <= 5) check("t3_ready2", s_ready[2], 1'b0);
    end
    check("t3_busy_end", s_busy, 1'b0);

    // 4: requester 1 drops valid after one word, requester 3 is next.
    do_reset();
    cycle(4'b1010, 1'b0, 1'b0);
    cycle(4'b1010, 1'b0, 1'b0);
    check("t4_first", s_wen, 1'b1);
    cycle(4'b1000, 1'b0, 1'b0);
    check("t4_release_wen", s_wen, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    check("t4_bubble", s_busy, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    check("t4_grant3", s_grant, 4'b1000);

    // 5: reset mid-burst with owner 2 after two words.
    do_reset();
    repeat (3) cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b1);
    check("t5_rst_wen", s_wen, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check("t5_grant", s_grant, 4'b0000);
    check("t5_busy", s_busy, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    check("t5_first", s_grant, 4'b0001);

    // 6: wrap-around from owner 3 to requester 0, then requester 2.
    do_reset();
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    for (int c = 2; c < 10; c++) begin
      cycle(4'b0101, 1'b0, 1'b0);
      if (c == 4) check("t6_wrap0", s_grant, 4'b0001);
      if (c == 9) check("t6_then2", s_grant, 4'b0100);
    end

    // Randomized traffic, back-pressure and occasional resets.
    rand_data = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cycle(N'($urandom) | N'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
